mcu_core_param: RTL and testbench

Parametrised successor to the fixed 8-bit MCU datapath. It integrates the program counter, instruction register, control FSM, register file, ALU and accumulator into one core. Width, register count and address space are configurable. It adds conditional branches on the zero/carry flags, immediate loads, a halt state and a synchronous PC restart. Instruction memory is external asynchronous ROM addressed by the core.

---
 rtl/mcu_pkg.sv | 56 +++++
 rtl/mcu_alu.sv | 31 +++
 rtl/mcu_core_param.sv | 128 ++++++++++++
 tb/tb_mcu_core_param.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the parametrised MCU core: opcodes, control states
// and the ALU function select.
package mcu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8
  } alu_sel_e;

  // Map an opcode onto the ALU function it needs; non-ALU opcodes pass B through.
  function automatic alu_sel_e alu_sel_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU. Result is {carry, value}; carry is meaningful for
// add/sub (bit DW of the widened sum) and for shifts (bit shifted out).
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_sel_e      sel,
  output logic [DW:0]   res
);

  // Select the operation; subtraction is a + ~b + 1 so carry=1 means no borrow.
  always_comb begin
    res = '0;
    case (sel)
      ALU_PASS: res = {1'b0, b};
      ALU_ADD:  res = {1'b0, a} + {1'b0, b};
      ALU_SUB:  res = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
      ALU_AND:  res = {1'b0, a & b};
      ALU_OR:   res = {1'b0, a | b};
      ALU_XOR:  res = {1'b0, a ^ b};
      ALU_NOT:  res = {1'b0, ~a};
      ALU_SHL:  res = {a, 1'b0};
      ALU_SHR:  res = {a[0], 1'b0, a[DW-1:1]};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/mcu_core_param.sv
// Parametrised accumulator MCU core: PC, IR, register file, control FSM and
// accumulator/flags. Instruction memory is an external asynchronous ROM.
//
// state   | meaning
// FETCH   | IR <- imem_data, PC <- PC+1
// DECODE  | latch the addressed register for the execute step
// EXECUTE | update acc / flags / register / PC, then FETCH (or HALT on HLT)
// HALT    | everything held; only resetPC or Reset leaves
module mcu_core_param
  import mcu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int PCW  = 8,
  parameter int NREG = 16,
  parameter int IW   = 4 + PCW
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           resetPC,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic [PCW-1:0] currentPC,
  output logic [DW-1:0]  acc_out,
  output logic           flag_z,
  output logic           flag_c,
  output logic           halted
);

  localparam int RIW = $clog2(NREG);

  state_e          state;
  logic [PCW-1:0]  pc;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   reg_val;

  logic [3:0]      opcode;
  logic [PCW-1:0]  operand;
  logic [RIW-1:0]  ridx;
  logic [DW-1:0]   imm_ext;
  alu_sel_e        alu_sel;
  logic [DW:0]     alu_res;

  assign opcode    = ir[IW-1:PCW];
  assign operand   = ir[PCW-1:0];
  assign ridx      = operand[RIW-1:0];
  assign imm_ext   = DW'(operand);
  assign alu_sel   = alu_sel_of(opcode);

  assign imem_addr = pc;
  assign currentPC = pc;
  assign acc_out   = acc;

  mcu_alu #(.DW(DW)) u_alu (
    .a   (acc),
    .b   (reg_val),
    .sel (alu_sel),
    .res (alu_res)
  );

  // Control FSM plus all architectural state; resetPC overrides every state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      reg_val <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      halted  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (resetPC) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= imem_data;
          pc    <= pc + PCW'(1);
          state <= DECODE;
        end
        DECODE: begin
          reg_val <= regs[ridx];
          state   <= EXECUTE;
        end
        EXECUTE: begin
          state <= FETCH;
          case (opcode)
            OP_LDR: begin
              acc    <= reg_val;
              flag_z <= (reg_val == '0);
            end
            OP_STR: regs[ridx] <= acc;
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
              acc    <= alu_res[DW-1:0];
              flag_z <= (alu_res[DW-1:0] == '0);
              flag_c <= alu_res[DW];
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              acc    <= alu_res[DW-1:0];
              flag_z <= (alu_res[DW-1:0] == '0);
              flag_c <= 1'b0;
            end
            OP_JMP: pc <= operand;
            OP_JZ:  if (flag_z) pc <= operand;
            OP_JC:  if (flag_c) pc <= operand;
            OP_LDI: begin
              acc    <= imm_ext;
              flag_z <= (imm_ext == '0);
            end
            OP_HLT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_core_param.sv
// Bench for mcu_core_param: a default-width core (DW=8, PCW=8, NREG=16) and a
// narrow/wide core (DW=16, PCW=4, NREG=4), each fed from a bench-owned ROM.
// Expected architectural state after each instruction is queued when the
// program is loaded and compared when the core reaches the next FETCH.
module tb_mcu_core_param;

  logic Clk;
  logic Reset;
  logic rpc1, rpc2;

  logic [7:0]  addr1, pc1;
  logic [11:0] data1;
  logic [7:0]  acc1;
  logic        z1, c1, h1;

  logic [3:0]  addr2, pc2;
  logic [7:0]  data2;
  logic [15:0] acc2;
  logic        z2, c2, h2;

  logic [11:0] rom1 [256];
  logic [7:0]  rom2 [16];

  assign data1 = rom1[addr1];
  assign data2 = rom2[addr2];

  mcu_core_param u_dut1 (
    .Clk(Clk), .Reset(Reset), .resetPC(rpc1),
    .imem_addr(addr1), .imem_data(data1), .currentPC(pc1),
    .acc_out(acc1), .flag_z(z1), .flag_c(c1), .halted(h1)
  );

  mcu_core_param #(.DW(16), .PCW(4), .NREG(4)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .resetPC(rpc2),
    .imem_addr(addr2), .imem_data(data2), .currentPC(pc2),
    .acc_out(acc2), .flag_z(z2), .flag_c(c2), .halted(h2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          cycles;
    string       name;
    logic [7:0]  pc;
    logic [15:0] acc;
    logic        z;
    logic        c;
    logic        h;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic void exp_push(int cyc, string nm, logic [7:0] pc, logic [15:0] acc,
                                   logic z, logic c, logic h);
    exp_t e;
    e.cycles = cyc; e.name = nm; e.pc = pc; e.acc = acc; e.z = z; e.c = c; e.h = h;
    sb_q.push_back(e);
  endfunction

  task automatic clear_rom1();
    for (int i = 0; i < 256; i++) rom1[i] = 12'h000;
  endtask

  task automatic do_reset();
    rpc1  = 1'b0;
    Reset = 1'b0;
    #3;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #2;
    checks++;
    if ({pc1, addr1, acc1, z1, c1, h1} !== 27'd0) begin
      failures++;
      $display("FAIL reset_dut1: got pc=%h addr=%h acc=%h z=%b c=%b halted=%b, want all zero",
               pc1, addr1, acc1, z1, c1, h1);
    end
    checks++;
    if ({pc2, addr2, acc2, z2, c2, h2} !== 27'd0) begin
      failures++;
      $display("FAIL reset_dut2: got pc=%h addr=%h acc=%h z=%b c=%b halted=%b, want all zero",
               pc2, addr2, acc2, z2, c2, h2);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_arith();
    exp_t e;
    clear_rom1();
    rom1[0]  = 12'hEFF; rom1[1]  = 12'h201; rom1[2]  = 12'hE01; rom1[3]  = 12'h301;
    rom1[4]  = 12'h401; rom1[5]  = 12'h101; rom1[6]  = 12'h900; rom1[7]  = 12'h602;
    rom1[8]  = 12'h701; rom1[9]  = 12'h800; rom1[10] = 12'h401; rom1[11] = 12'h301;
    rom1[12] = 12'h501; rom1[13] = 12'h701; rom1[14] = 12'h502;
    do_reset();
    exp_push(3, "ldi_ff",   8'h01, 16'h00FF, 0, 0, 0);
    exp_push(3, "str_r1",   8'h02, 16'h00FF, 0, 0, 0);
    exp_push(3, "ldi_01",   8'h03, 16'h0001, 0, 0, 0);
    exp_push(3, "add_wrap", 8'h04, 16'h0000, 1, 1, 0);
    exp_push(3, "sub_r1",   8'h05, 16'h0001, 0, 0, 0);
    exp_push(3, "ldr_r1",   8'h06, 16'h00FF, 0, 0, 0);
    exp_push(3, "shl_ff",   8'h07, 16'h00FE, 0, 1, 0);
    exp_push(3, "or_clr_c", 8'h08, 16'h00FE, 0, 0, 0);
    exp_push(3, "xor_r1",   8'h09, 16'h0001, 0, 0, 0);
    exp_push(3, "not",      8'h0A, 16'h00FE, 0, 0, 0);
    exp_push(3, "sub_borr", 8'h0B, 16'h00FF, 0, 0, 0);
    exp_push(3, "add_carr", 8'h0C, 16'h00FE, 0, 1, 0);
    exp_push(3, "and_clr",  8'h0D, 16'h00FE, 0, 0, 0);
    exp_push(3, "xor_01",   8'h0E, 16'h0001, 0, 0, 0);
    exp_push(3, "and_zero", 8'h0F, 16'h0000, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
  endtask

  task automatic test_shift();
    exp_t e;
    clear_rom1();
    rom1[0] = 12'hE80; rom1[1] = 12'h900; rom1[2] = 12'hE01; rom1[3] = 12'hA00;
    rom1[4] = 12'hE81; rom1[5] = 12'hA00; rom1[6] = 12'h900;
    do_reset();
    exp_push(3, "ldi_80",   8'h01, 16'h0080, 0, 0, 0);
    exp_push(3, "shl_80",   8'h02, 16'h0000, 1, 1, 0);
    exp_push(3, "ldi_keepc",8'h03, 16'h0001, 0, 1, 0);
    exp_push(3, "shr_01",   8'h04, 16'h0000, 1, 1, 0);
    exp_push(3, "ldi_81",   8'h05, 16'h0081, 0, 1, 0);
    exp_push(3, "shr_81",   8'h06, 16'h0040, 0, 1, 0);
    exp_push(3, "shl_40",   8'h07, 16'h0080, 0, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    clear_rom1();
    rom1[8'h00] = 12'hE00; rom1[8'h01] = 12'h300; rom1[8'h02] = 12'hC20;
    rom1[8'h20] = 12'hE07; rom1[8'h21] = 12'hC30; rom1[8'h22] = 12'hD30;
    rom1[8'h23] = 12'hEFF; rom1[8'h24] = 12'h900; rom1[8'h25] = 12'hD40;
    rom1[8'h40] = 12'hBF0; rom1[8'hF0] = 12'h000; rom1[8'hF1] = 12'hBFF;
    rom1[8'hFF] = 12'h000;
    do_reset();
    exp_push(3, "ldi_0",     8'h01, 16'h0000, 1, 0, 0);
    exp_push(3, "add_r0",    8'h02, 16'h0000, 1, 0, 0);
    exp_push(3, "jz_taken",  8'h20, 16'h0000, 1, 0, 0);
    exp_push(3, "ldi_7",     8'h21, 16'h0007, 0, 0, 0);
    exp_push(3, "jz_not",    8'h22, 16'h0007, 0, 0, 0);
    exp_push(3, "jc_not",    8'h23, 16'h0007, 0, 0, 0);
    exp_push(3, "ldi_ff",    8'h24, 16'h00FF, 0, 0, 0);
    exp_push(3, "shl_setc",  8'h25, 16'h00FE, 0, 1, 0);
    exp_push(3, "jc_taken",  8'h40, 16'h00FE, 0, 1, 0);
    exp_push(3, "jmp_f0",    8'hF0, 16'h00FE, 0, 1, 0);
    exp_push(3, "nop_f0",    8'hF1, 16'h00FE, 0, 1, 0);
    exp_push(3, "jmp_ff",    8'hFF, 16'h00FE, 0, 1, 0);
    exp_push(3, "pc_wrap",   8'h00, 16'h00FE, 0, 1, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    clear_rom1();
    rom1[0] = 12'hE3C; rom1[5] = 12'hF00;
    do_reset();
    exp_push(18, "hlt_enter", 8'h06, 16'h003C, 0, 0, 1);
    exp_push(50, "hlt_hold",  8'h06, 16'h003C, 0, 0, 1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
    rpc1 = 1'b1;
    @(posedge Clk); #1;
    rpc1 = 1'b0;
    exp_push(0, "resetpc",       8'h00, 16'h003C, 0, 0, 0);
    exp_push(3, "resetpc_refet", 8'h01, 16'h003C, 0, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    clear_rom1();
    rom1[0] = 12'hE05; rom1[1] = 12'h302; rom1[2] = 12'h202; rom1[3] = 12'h302;
    do_reset();
    exp_push(3, "mid_ldi",  8'h01, 16'h0005, 0, 0, 0);
    exp_push(3, "mid_add0", 8'h02, 16'h0005, 0, 0, 0);
    exp_push(3, "mid_str",  8'h03, 16'h0005, 0, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
    // Two more edges place the ADD at address 3 in EXECUTE.
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    checks++;
    if ({pc1, acc1, z1, c1, h1} !== 19'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got pc=%h acc=%h z=%b c=%b halted=%b, want all zero",
               pc1, acc1, z1, c1, h1);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (addr1 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_addr: got imem_addr=%h, want 00", addr1);
    end
    // r2 must have been cleared, so ADD r2 leaves acc at 5.
    exp_push(3, "post_ldi",  8'h01, 16'h0005, 0, 0, 0);
    exp_push(3, "post_add",  8'h02, 16'h0005, 0, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({pc1, 8'h00, acc1, z1, c1, h1} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc1, acc1, z1, c1, h1, e.pc, e.acc[7:0], e.z, e.c, e.h);
      end
    end
  endtask

  task automatic test_param();
    exp_t e;
    for (int i = 0; i < 16; i++) rom2[i] = 8'h00;
    rom2[0] = 8'hEA; rom2[1] = 8'h21; rom2[2] = 8'hE0; rom2[3] = 8'h15;
    do_reset();
    exp_push(3,  "p_ldi_a",   8'h01, 16'h000A, 0, 0, 0);
    exp_push(3,  "p_str_r1",  8'h02, 16'h000A, 0, 0, 0);
    exp_push(3,  "p_ldi_0",   8'h03, 16'h0000, 1, 0, 0);
    exp_push(3,  "p_ldr_idx", 8'h04, 16'h000A, 0, 0, 0);
    exp_push(33, "p_nop_f",   8'h0F, 16'h000A, 0, 0, 0);
    exp_push(3,  "p_wrap",    8'h00, 16'h000A, 0, 0, 0);
    exp_push(3,  "p_refetch", 8'h01, 16'h000A, 0, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.cycles) @(posedge Clk);
      #1;
      checks++;
      if ({4'h0, pc2, acc2, z2, c2, h2} !== {e.pc, e.acc, e.z, e.c, e.h}) begin
        failures++;
        $display("FAIL %s: got pc=%h acc=%h z=%b c=%b halted=%b, want pc=%h acc=%h z=%b c=%b halted=%b",
                 e.name, pc2, acc2, z2, c2, h2, e.pc, e.acc, e.z, e.c, e.h);
      end
    end
  endtask

  initial begin
    rpc1  = 1'b0;
    rpc2  = 1'b0;
    Reset = 1'b0;
    clear_rom1();
    for (int i = 0; i < 16; i++) rom2[i] = 8'h00;
    test_reset();
    test_arith();
    test_shift();
    test_branch();
    test_halt();
    test_reset_mid();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
